// File: rtl/branch_flush_ctrl.sv
// Pipeline front-end controller: applies branch/jump redirects with an optional multi-cycle IF/ID flush,
// load-use stalls and memory-busy freezes, and counts flush and stall events.
module branch_flush_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_req,
    input  logic [15:0]          target_pc,
    input  logic                 idex_mem_read,
    input  logic [3:0]           idex_rd,
    input  logic [3:0]           ifid_rs1,
    input  logic [3:0]           ifid_rs2,
    input  logic                 mem_busy,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 pc_sel,
    output logic [15:0]          redirect_pc,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_FLUSH = 2'b01,
        S_HOLD  = 2'b10,
        S_ILL   = 2'b11
    } state_t;

    localparam logic [2:0] LP_CNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam state_t     LP_AFTER_REDIRECT = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [15:0]           r_pending_pc;
    logic [CNT_WIDTH-1:0]  r_flush_count;
    logic [CNT_WIDTH-1:0]  r_stall_count;

    state_t                w_state_nxt;
    logic [2:0]            w_cnt_nxt;
    logic [15:0]           w_pending_nxt;
    logic                  w_flush_inc;
    logic                  w_stall_inc;
    logic                  w_lu;

    assign w_lu = idex_mem_read & (idex_rd != 4'd0) &
                  ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pc_sel        = 1'b0;
        redirect_pc   = 16'h0000;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending_pc;
        w_flush_inc   = 1'b0;
        w_stall_inc   = 1'b0;

        case (r_state)
            S_RUN: begin
                if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    if (flush_req) begin
                        w_pending_nxt = target_pc;
                        w_state_nxt   = S_HOLD;
                    end
                end else if (flush_req) begin
                    // A coinciding load-use hazard is dropped: the stalled instruction is squashed.
                    pc_sel      = 1'b1;
                    redirect_pc = target_pc;
                    ifid_flush  = 1'b1;
                    w_flush_inc = 1'b1;
                    w_cnt_nxt   = LP_CNT_INIT;
                    w_state_nxt = LP_AFTER_REDIRECT;
                end else if (w_lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    w_stall_inc = 1'b1;
                end
            end
            S_HOLD: begin
                if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end else begin
                    pc_sel      = 1'b1;
                    redirect_pc = r_pending_pc;
                    ifid_flush  = 1'b1;
                    w_flush_inc = 1'b1;
                    w_cnt_nxt   = LP_CNT_INIT;
                    w_state_nxt = LP_AFTER_REDIRECT;
                end
            end
            S_FLUSH: begin
                // Requests and hazards seen here come from wrong-path instructions.
                if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end else begin
                    ifid_flush = 1'b1;
                    w_cnt_nxt  = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pc_sel      = 1'b0;
            redirect_pc = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_cnt         <= 3'd0;
            r_pending_pc  <= 16'h0000;
            r_flush_count <= '0;
            r_stall_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pending_pc <= w_pending_nxt;
            if (w_flush_inc && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_WIDTH'(1);
            end
            if (w_stall_inc && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_WIDTH'(1);
            end
        end
    end

    assign flush_count = r_flush_count;
    assign stall_count = r_stall_count;
    assign state       = r_state;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed bench for branch_flush_ctrl: a vector table for the single-cycle-flush build plus
// hand-written sequences for multi-cycle flush, reset mid-flush and counter saturation.
module tb_branch_flush_ctrl;

    logic        clk;
    logic        rst;
    logic        flush_req;
    logic [15:0] target_pc;
    logic        idex_mem_read;
    logic [3:0]  idex_rd;
    logic [3:0]  ifid_rs1;
    logic [3:0]  ifid_rs2;
    logic        mem_busy;

    logic        d1_pw, d1_iw, d1_fl, d1_bub, d1_sel;
    logic [15:0] d1_rpc, d1_fc, d1_sc;
    logic [1:0]  d1_st;

    logic        d3_pw, d3_iw, d3_fl, d3_bub, d3_sel;
    logic [15:0] d3_rpc, d3_fc, d3_sc;
    logic [1:0]  d3_st;

    logic        ds_pw, ds_iw, ds_fl, ds_bub, ds_sel;
    logic [15:0] ds_rpc;
    logic [1:0]  ds_fc, ds_sc;
    logic [1:0]  ds_st;

    int errors = 0;
    int checks = 0;

    branch_flush_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .flush_req(flush_req), .target_pc(target_pc),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .mem_busy(mem_busy), .pc_write(d1_pw), .ifid_write(d1_iw), .ifid_flush(d1_fl),
        .idex_bubble(d1_bub), .pc_sel(d1_sel), .redirect_pc(d1_rpc), .flush_count(d1_fc),
        .stall_count(d1_sc), .state(d1_st));

    branch_flush_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(16)) dut3 (
        .clk(clk), .rst(rst), .flush_req(flush_req), .target_pc(target_pc),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .mem_busy(mem_busy), .pc_write(d3_pw), .ifid_write(d3_iw), .ifid_flush(d3_fl),
        .idex_bubble(d3_bub), .pc_sel(d3_sel), .redirect_pc(d3_rpc), .flush_count(d3_fc),
        .stall_count(d3_sc), .state(d3_st));

    branch_flush_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .flush_req(flush_req), .target_pc(target_pc),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .mem_busy(mem_busy), .pc_write(ds_pw), .ifid_write(ds_iw), .ifid_flush(ds_fl),
        .idex_bubble(ds_bub), .pc_sel(ds_sel), .redirect_pc(ds_rpc), .flush_count(ds_fc),
        .stall_count(ds_sc), .state(ds_st));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fr;
        logic [15:0] tpc;
        logic        mr;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        mb;
        logic        pw;
        logic        iw;
        logic        fl;
        logic        bub;
        logic        sel;
        logic [15:0] rpc;
        logic [15:0] fc;
        logic [15:0] sc;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fr, input logic [15:0] tpc, input logic mr,
                         input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic mb);
        rst           = r;
        flush_req     = fr;
        target_pc     = tpc;
        idex_mem_read = mr;
        idex_rd       = rd;
        ifid_rs1      = rs1;
        ifid_rs2      = rs2;
        mem_busy      = mb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst fr tpc      mr rd rs1 rs2 mb | pw iw fl bub sel rpc     fc sc st
        tbl[0]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 16'h0000, 0, 0, 2'd0};
        tbl[1]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 16'h0000, 0, 0, 2'd0};
        tbl[2]  = '{0, 1, 16'h0040, 1, 3, 0, 3, 0,   1, 1, 1, 0, 1, 16'h0040, 0, 0, 2'd0};
        tbl[3]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 16'h0000, 1, 0, 2'd0};
        tbl[4]  = '{0, 0, 16'h0000, 1, 3, 0, 3, 0,   0, 0, 0, 1, 0, 16'h0000, 1, 0, 2'd0};
        tbl[5]  = '{0, 0, 16'h0000, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 16'h0000, 1, 1, 2'd0};
        tbl[6]  = '{0, 0, 16'h0000, 1, 5, 5, 2, 0,   0, 0, 0, 1, 0, 16'h0000, 1, 1, 2'd0};
        tbl[7]  = '{0, 0, 16'h0000, 0, 5, 5, 2, 0,   1, 1, 0, 0, 0, 16'h0000, 1, 2, 2'd0};
        tbl[8]  = '{0, 0, 16'h0000, 1, 5, 5, 2, 1,   0, 0, 0, 0, 0, 16'h0000, 1, 2, 2'd0};
        tbl[9]  = '{0, 1, 16'h1234, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 16'h0000, 1, 2, 2'd0};
        tbl[10] = '{0, 1, 16'h5555, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 16'h0000, 1, 2, 2'd2};
        tbl[11] = '{0, 0, 16'h0000, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 16'h0000, 1, 2, 2'd2};
        tbl[12] = '{0, 0, 16'h0000, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 16'h0000, 1, 2, 2'd2};
        tbl[13] = '{0, 0, 16'h0000, 1, 5, 5, 2, 0,   1, 1, 1, 0, 1, 16'h1234, 1, 2, 2'd2};
        tbl[14] = '{0, 0, 16'h0000, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 16'h0000, 2, 2, 2'd0};
        tbl[15] = '{0, 1, 16'hBEEF, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 16'h0000, 2, 2, 2'd0};
        tbl[16] = '{1, 0, 16'h0000, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 16'h0000, 2, 2, 2'd2};
        tbl[17] = '{0, 0, 16'h0000, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 16'h0000, 0, 0, 2'd0};

        drive(1, 0, 16'h0000, 0, 0, 0, 0, 0);
        step();

        // Single-cycle flush build, table driven
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].fr, tbl[i].tpc, tbl[i].mr, tbl[i].rd, tbl[i].rs1,
                  tbl[i].rs2, tbl[i].mb);
            @(negedge clk);
            check($sformatf("v%0d pc_write", i),    32'(d1_pw),  32'(tbl[i].pw));
            check($sformatf("v%0d ifid_write", i),  32'(d1_iw),  32'(tbl[i].iw));
            check($sformatf("v%0d ifid_flush", i),  32'(d1_fl),  32'(tbl[i].fl));
            check($sformatf("v%0d idex_bubble", i), 32'(d1_bub), 32'(tbl[i].bub));
            check($sformatf("v%0d pc_sel", i),      32'(d1_sel), 32'(tbl[i].sel));
            check($sformatf("v%0d redirect_pc", i), 32'(d1_rpc), 32'(tbl[i].rpc));
            check($sformatf("v%0d flush_count", i), 32'(d1_fc),  32'(tbl[i].fc));
            check($sformatf("v%0d stall_count", i), 32'(d1_sc),  32'(tbl[i].sc));
            check($sformatf("v%0d state", i),       32'(d1_st),  32'(tbl[i].st));
            step();
        end

        // Three-cycle flush with a busy cycle in the middle and wrong-path requests
        drive(1, 0, 16'h0000, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 16'h0080, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("m3 redirect pc_sel", 32'(d3_sel), 32'd1);
        check("m3 redirect pc", 32'(d3_rpc), 32'h0080);
        check("m3 redirect flush", 32'(d3_fl), 32'd1);
        check("m3 redirect state", 32'(d3_st), 32'd0);
        step();
        drive(0, 0, 16'h0000, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("m3 busy state", 32'(d3_st), 32'd1);
        check("m3 busy flush", 32'(d3_fl), 32'd0);
        check("m3 busy pc_write", 32'(d3_pw), 32'd0);
        check("m3 busy ifid_write", 32'(d3_iw), 32'd0);
        step();
        drive(0, 1, 16'h0999, 1, 3, 0, 3, 0);
        @(negedge clk);
        check("m3 f2 state", 32'(d3_st), 32'd1);
        check("m3 f2 flush", 32'(d3_fl), 32'd1);
        check("m3 f2 pc_write", 32'(d3_pw), 32'd1);
        check("m3 f2 pc_sel", 32'(d3_sel), 32'd0);
        check("m3 f2 bubble", 32'(d3_bub), 32'd0);
        step();
        @(negedge clk);
        check("m3 f3 state", 32'(d3_st), 32'd1);
        check("m3 f3 flush", 32'(d3_fl), 32'd1);
        check("m3 f3 pc_sel", 32'(d3_sel), 32'd0);
        check("m3 f3 stall_count", 32'(d3_sc), 32'd0);
        step();
        drive(0, 0, 16'h0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("m3 done state", 32'(d3_st), 32'd0);
        check("m3 done flush", 32'(d3_fl), 32'd0);
        check("m3 done flush_count", 32'(d3_fc), 32'd1);
        check("m3 done pc_sel", 32'(d3_sel), 32'd0);
        step();

        // Reset while flushing
        drive(0, 1, 16'h0010, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 16'h0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rf state before", 32'(d3_st), 32'd1);
        check("rf flush_count before", 32'(d3_fc), 32'd2);
        check("rf rst flush", 32'(d3_fl), 32'd1);
        check("rf rst bubble", 32'(d3_bub), 32'd1);
        check("rf rst pc_write", 32'(d3_pw), 32'd0);
        step();
        drive(0, 0, 16'h0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rf state after", 32'(d3_st), 32'd0);
        check("rf flush_count after", 32'(d3_fc), 32'd0);
        check("rf stall_count after", 32'(d3_sc), 32'd0);
        check("rf flush after", 32'(d3_fl), 32'd0);
        step();

        // Two-bit counter saturation over five stalls
        drive(1, 0, 16'h0000, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 16'h0000, 1, 3, 0, 3, 0);
            @(negedge clk);
            check($sformatf("sat stall%0d bubble", k), 32'(ds_bub), 32'd1);
            check($sformatf("sat stall%0d count", k), 32'(ds_sc), (k < 3) ? 32'(k) : 32'd3);
            step();
        end
        drive(0, 0, 16'h0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sat final stall_count", 32'(ds_sc), 32'd3);
        check("sat final flush_count", 32'(ds_fc), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
